// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: funct codes, ALU-op and forwarding
// select codes, ALU control values and the mul/div sequencer states.
package mips_pkg;

    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_RSVD  = 2'b11;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_ZERO  = 2'b11;

    typedef enum logic [3:0] {
        ALU_CTL_ADD,
        ALU_CTL_SUB,
        ALU_CTL_AND,
        ALU_CTL_OR,
        ALU_CTL_NOR,
        ALU_CTL_SLT,
        ALU_CTL_MFHI,
        ALU_CTL_MFLO,
        ALU_CTL_MULDIV,
        ALU_CTL_ZERO
    } alu_ctl_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } muldiv_state_e;

    // Maps the ALU-op field plus funct onto a single ALU control value.
    function automatic alu_ctl_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_ctl_e ctl;
        ctl = ALU_CTL_ZERO;
        case (alu_op)
            ALU_OP_ADD: ctl = ALU_CTL_ADD;
            ALU_OP_SUB: ctl = ALU_CTL_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FUNCT_ADD:   ctl = ALU_CTL_ADD;
                    FUNCT_SUB:   ctl = ALU_CTL_SUB;
                    FUNCT_AND:   ctl = ALU_CTL_AND;
                    FUNCT_OR:    ctl = ALU_CTL_OR;
                    FUNCT_NOR:   ctl = ALU_CTL_NOR;
                    FUNCT_SLT:   ctl = ALU_CTL_SLT;
                    FUNCT_MFHI:  ctl = ALU_CTL_MFHI;
                    FUNCT_MFLO:  ctl = ALU_CTL_MFLO;
                    FUNCT_MULT,
                    FUNCT_MULTU,
                    FUNCT_DIV,
                    FUNCT_DIVU:  ctl = ALU_CTL_MULDIV;
                    default:     ctl = ALU_CTL_ZERO;
                endcase
            end
            default: ctl = ALU_CTL_ZERO;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one radix-2 shift-add or restoring
// shift-subtract step per cycle on magnitudes, then a sign fix-up in FIX.
// Assumes WIDTH >= 2.
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_e          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic [WIDTH-1:0]       a_orig_q, a_orig_d;
    logic                   signed_q, signed_d;
    logic                   is_div_q, is_div_d;
    logic                   neg_a_q, neg_a_d;
    logic                   neg_b_q, neg_b_d;
    logic                   div0_q, div0_d;

    logic [WIDTH-1:0]       mag_a, mag_b, mul_addend;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH+1:0]       div_diff;
    logic [2*WIDTH-1:0]     prod_neg;
    logic [WIDTH-1:0]       quot, rem;

    assign mag_a = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign mag_b = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

    assign mul_addend = acc_q[0] ? opb_q : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign div_diff   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_q};

    // Sequencer state and datapath registers, cleared synchronously.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            a_orig_q <= '0;
            signed_q <= 1'b0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            a_orig_q <= a_orig_d;
            signed_q <= signed_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div0_q   <= div0_d;
        end
    end

    // Next state: latch operands on start, step WIDTH times, then one FIX cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        a_orig_d = a_orig_q;
        signed_d = signed_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d    = {{WIDTH{1'b0}}, mag_a};
                    opb_d    = mag_b;
                    a_orig_d = a_i;
                    signed_d = signed_i;
                    is_div_d = is_div_i;
                    neg_a_d  = signed_i && a_i[WIDTH-1];
                    neg_b_d  = signed_i && b_i[WIDTH-1];
                    div0_d   = (b_i == {WIDTH{1'b0}});
                    cnt_d    = CNT_W'(WIDTH - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (div_diff[WIDTH+1]) begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign prod_neg = ~acc_q + 1'b1;
    assign quot     = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];

    // Sign fix-up of the magnitude result; divide-by-zero bypasses it.
    always_comb begin
        hi_o = rem;
        lo_o = quot;
        if (!is_div_q) begin
            if (neg_a_q ^ neg_b_q) begin
                {hi_o, lo_o} = prod_neg;
            end else begin
                {hi_o, lo_o} = acc_q;
            end
        end else if (div0_q) begin
            hi_o = a_orig_q;
            lo_o = {WIDTH{1'b1}};
        end else begin
            lo_o = (neg_a_q ^ neg_b_q) ? (~quot + 1'b1) : quot;
            hi_o = neg_a_q ? (~rem + 1'b1) : rem;
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = (state_q == FIX);

endmodule

// File: rtl/ex_stage_muldiv.sv
// Execute stage: operand forwarding, ALU-source mux, ALU, result mux and the
// architectural HI/LO registers fed by the iterative mul/div unit.
module ex_stage_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_valid,
    input  logic [31:0]      id_ex_instr,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [WIDTH-1:0] id_ex_imm_value,
    input  logic [WIDTH-1:0] ex_mem_alu_result,
    input  logic [WIDTH-1:0] mem_wb_write_back_result,
    input  logic             id_ex_alu_src,
    input  logic [1:0]       id_ex_alu_op,
    input  logic [1:0]       Forward_A,
    input  logic [1:0]       Forward_B,
    output logic [WIDTH-1:0] alu_in2_out,
    output logic [WIDTH-1:0] alu_result,
    output logic             stall
);

    logic [5:0]       funct;
    logic [WIDTH-1:0] op_a, fwd_b, op_b;
    alu_ctl_e         alu_ctl;
    logic             is_muldiv;
    logic             md_start, md_busy, md_done;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             unused_instr_bits;

    assign funct             = id_ex_instr[5:0];
    assign unused_instr_bits = ^id_ex_instr[31:6];
    assign alu_ctl           = alu_decode(id_ex_alu_op, funct);
    assign is_muldiv         = (alu_ctl == ALU_CTL_MULDIV);

    // Operand A forwarding mux.
    always_comb begin
        case (Forward_A)
            FWD_REG:   op_a = reg1;
            FWD_MEMWB: op_a = mem_wb_write_back_result;
            FWD_EXMEM: op_a = ex_mem_alu_result;
            default:   op_a = '0;
        endcase
    end

    // Operand B forwarding mux; its output is also the store data.
    always_comb begin
        case (Forward_B)
            FWD_REG:   fwd_b = reg2;
            FWD_MEMWB: fwd_b = mem_wb_write_back_result;
            FWD_EXMEM: fwd_b = ex_mem_alu_result;
            default:   fwd_b = '0;
        endcase
    end

    assign alu_in2_out = fwd_b;
    assign op_b        = id_ex_alu_src ? id_ex_imm_value : fwd_b;

    generate
        if (MULDIV_EN) begin : g_muldiv
            logic             md_signed, md_is_div;
            logic [WIDTH-1:0] md_hi, md_lo;

            assign md_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
            assign md_is_div = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
            // A muldiv already in CALC or FIX is the one being executed, never a new issue.
            assign md_start  = id_ex_valid && is_muldiv && !md_busy && !md_done;

            muldiv_iter #(
                .WIDTH (WIDTH)
            ) u_muldiv (
                .clk_i    (clk),
                .reset_i  (reset),
                .start_i  (md_start),
                .signed_i (md_signed),
                .is_div_i (md_is_div),
                .a_i      (op_a),
                .b_i      (fwd_b),
                .busy_o   (md_busy),
                .done_o   (md_done),
                .hi_o     (md_hi),
                .lo_o     (md_lo)
            );

            // HI/LO capture the fixed-up result at the edge that ends FIX.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hi_q <= '0;
                    lo_q <= '0;
                end else if (md_done) begin
                    hi_q <= md_hi;
                    lo_q <= md_lo;
                end
            end
        end else begin : g_no_muldiv
            logic unused_md_inputs;
            assign unused_md_inputs = ^{clk, reset, id_ex_valid, is_muldiv};
            assign md_start = 1'b0;
            assign md_busy  = 1'b0;
            assign md_done  = 1'b0;
            assign hi_q     = '0;
            assign lo_q     = '0;
        end
    endgenerate

    assign stall = md_start || md_busy;

    // Result mux; a stalled cycle sends a zero bubble into EX/MEM.
    always_comb begin
        alu_result = '0;
        if (!stall) begin
            case (alu_ctl)
                ALU_CTL_ADD:  alu_result = op_a + op_b;
                ALU_CTL_SUB:  alu_result = op_a - op_b;
                ALU_CTL_AND:  alu_result = op_a & op_b;
                ALU_CTL_OR:   alu_result = op_a | op_b;
                ALU_CTL_NOR:  alu_result = ~(op_a | op_b);
                ALU_CTL_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                ALU_CTL_MFHI: alu_result = hi_q;
                ALU_CTL_MFLO: alu_result = lo_q;
                default:      alu_result = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Randomised scoreboard bench for ex_stage_muldiv, with a second instance
// built without the mul/div unit sharing the same inputs.
module tb_ex_stage_muldiv;

    localparam int W = 32;

    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_MFHI = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_ex_valid;
    logic [31:0]  id_ex_instr;
    logic [W-1:0] reg1, reg2, imm, exm, mwb;
    logic         alu_src;
    logic [1:0]   alu_op, fwd_a, fwd_b;
    logic [W-1:0] in2_out, result, in2_out0, result0;
    logic         stall, stall0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] in2;
        logic        stall;
        logic [31:0] res0;
        logic        stall0;
    } exp_t;

    exp_t        expQ[$];
    string       nameQ[$];
    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] modHi = '0;
    logic [31:0] modLo = '0;
    exp_t        monExp;
    string       monName;

    always #5 clk = ~clk;

    ex_stage_muldiv #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid), .id_ex_instr(id_ex_instr),
        .reg1(reg1), .reg2(reg2), .id_ex_imm_value(imm), .ex_mem_alu_result(exm),
        .mem_wb_write_back_result(mwb), .id_ex_alu_src(alu_src), .id_ex_alu_op(alu_op),
        .Forward_A(fwd_a), .Forward_B(fwd_b), .alu_in2_out(in2_out), .alu_result(result),
        .stall(stall)
    );

    ex_stage_muldiv #(.WIDTH(W), .MULDIV_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid), .id_ex_instr(id_ex_instr),
        .reg1(reg1), .reg2(reg2), .id_ex_imm_value(imm), .ex_mem_alu_result(exm),
        .mem_wb_write_back_result(mwb), .id_ex_alu_src(alu_src), .id_ex_alu_op(alu_op),
        .Forward_A(fwd_a), .Forward_B(fwd_b), .alu_in2_out(in2_out0), .alu_result(result0),
        .stall(stall0)
    );

    function automatic logic [31:0] pickFwd(input logic [1:0] sel, input logic [31:0] r, m, e);
        case (sel)
            2'b00:   return r;
            2'b01:   return m;
            2'b10:   return e;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic isMulDiv(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic [31:0] modelAlu(input logic [1:0] op, input logic [5:0] f,
                                             input logic [31:0] a, b, hi, lo);
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: begin
                case (f)
                    F_ADD:   return a + b;
                    F_SUB:   return a - b;
                    F_AND:   return a & b;
                    F_OR:    return a | b;
                    F_NOR:   return ~(a | b);
                    F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    F_MFHI:  return hi;
                    F_MFLO:  return lo;
                    default: return 32'd0;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    // Architectural HI/LO update using plain integer arithmetic.
    task automatic modelMulDiv(input logic [5:0] f, input logic [31:0] a, b);
        logic [63:0] p;
        int ia, ib;
        ia = a;
        ib = b;
        case (f)
            F_MULT: begin
                p = longint'(ia) * longint'(ib);
                {modHi, modLo} = p;
            end
            F_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                {modHi, modLo} = p;
            end
            F_DIV: begin
                if (b == 32'd0) begin
                    modLo = 32'hFFFF_FFFF; modHi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    modLo = 32'h8000_0000; modHi = 32'd0;
                end else begin
                    modLo = ia / ib; modHi = ia % ib;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    modLo = 32'hFFFF_FFFF; modHi = a;
                end else begin
                    modLo = a / b; modHi = a % b;
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    // One clock of stimulus; pushes the expected response for this cycle.
    task automatic driveCycle(input logic v, input logic [5:0] f, input logic [31:0] r1, r2, im, em, mw,
                              input logic [1:0] op, input logic src, input logic [1:0] sa, sb,
                              input logic rst, input logic expStall, input string name);
        exp_t e;
        logic [31:0] rnd, a, bf, b;
        @(posedge clk);
        #1;
        rnd = $urandom();
        reset = rst; id_ex_valid = v; id_ex_instr = {rnd[31:6], f};
        reg1 = r1; reg2 = r2; imm = im; exm = em; mwb = mw;
        alu_op = op; alu_src = src; fwd_a = sa; fwd_b = sb;
        a  = pickFwd(sa, r1, mw, em);
        bf = pickFwd(sb, r2, mw, em);
        b  = src ? im : bf;
        e.in2    = bf;
        e.stall  = expStall;
        e.res    = expStall ? 32'd0 : modelAlu(op, f, a, b, modHi, modLo);
        e.stall0 = 1'b0;
        e.res0   = modelAlu(op, f, a, b, 32'd0, 32'd0);
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    // One instruction: a valid muldiv holds for WIDTH+1 stalled cycles plus FIX.
    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [31:0] r1, r2, im, em, mw,
                                 input logic [1:0] op, input logic src, input logic [1:0] sa, sb,
                                 input string name);
        if (v && op == 2'b10 && isMulDiv(f)) begin
            for (int i = 0; i < W + 1; i++)
                driveCycle(v, f, r1, r2, im, em, mw, op, src, sa, sb, 1'b0, 1'b1, name);
            driveCycle(v, f, r1, r2, im, em, mw, op, src, sa, sb, 1'b0, 1'b0, {name, "_fix"});
            modelMulDiv(f, pickFwd(sa, r1, mw, em), pickFwd(sb, r2, mw, em));
        end else begin
            driveCycle(v, f, r1, r2, im, em, mw, op, src, sa, sb, 1'b0, 1'b0, name);
        end
    endtask

    task automatic rOp(input logic [5:0] f, input logic [31:0] a, b, input string n);
        applyStimulus(1'b1, f, a, b, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 2'b00, 2'b00, n);
    endtask

    function automatic logic [31:0] corner();
        case ($urandom_range(0, 8))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'd7;
            6:       return 32'hFFFF_FFF9;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: pops one expectation per cycle and compares all outputs.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            checkOutput({monName, ".result"}, result, monExp.res);
            checkOutput({monName, ".in2"}, in2_out, monExp.in2);
            checkOutput({monName, ".stall"}, {31'd0, stall}, {31'd0, monExp.stall});
            checkOutput({monName, ".result_noMD"}, result0, monExp.res0);
            checkOutput({monName, ".stall_noMD"}, {31'd0, stall0}, {31'd0, monExp.stall0});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] f;
        logic [5:0] fList [8];
        fList = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_MFHI, F_MFLO};
        reset = 1'b1; id_ex_valid = 1'b0; id_ex_instr = '0;
        reg1 = '0; reg2 = '0; imm = '0; exm = '0; mwb = '0;
        alu_op = 2'b00; alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset state");
        rOp(F_MFHI, 32'd0, 32'd0, "reset_mfhi");
        rOp(F_MFLO, 32'd0, 32'd0, "reset_mflo");

        $display("[TB] forwarding and ALU");
        applyStimulus(1, F_SUB, 5, 3, 0, 7, 9, 2'b10, 0, 2'b10, 2'b00, "fwd_a_exmem_sub");
        applyStimulus(1, F_SUB, 5, 3, 0, 7, 9, 2'b10, 0, 2'b10, 2'b01, "fwd_b_memwb");
        applyStimulus(1, F_ADD, 5, 3, 100, 7, 9, 2'b00, 1, 2'b01, 2'b11, "imm_add");
        applyStimulus(1, F_ADD, 5, 3, 0, 7, 9, 2'b11, 0, 2'b00, 2'b00, "alu_op_rsvd");
        rOp(F_SLT, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        rOp(6'h3F, 32'd5, 32'd6, "funct_undef");

        $display("[TB] directed mul/div");
        rOp(F_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
        rOp(F_MFHI, 0, 0, "multu_hi");
        rOp(F_MFLO, 0, 0, "multu_lo");
        rOp(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        rOp(F_MFLO, 0, 0, "div_lo");
        rOp(F_MFHI, 0, 0, "div_hi");
        rOp(F_DIVU, 32'd7, 32'd0, "divu_by0");
        rOp(F_MFLO, 0, 0, "divu0_lo");
        rOp(F_MFHI, 0, 0, "divu0_hi");
        rOp(F_MULT, 32'h8000_0000, 32'hFFFF_FFFF, "mult_min_m1");
        rOp(F_MFHI, 0, 0, "mult_min_hi");
        rOp(F_MFLO, 0, 0, "mult_min_lo");
        rOp(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        rOp(F_MFLO, 0, 0, "div_min_lo");
        rOp(F_MFHI, 0, 0, "div_min_hi");
        applyStimulus(0, F_MULT, 3, 4, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, "invalid_mult");
        rOp(F_MFLO, 0, 0, "after_invalid_lo");

        $display("[TB] reset during divide");
        for (int i = 0; i < 11; i++)
            driveCycle(1, F_DIV, 32'd1000, 32'd3, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1'b0, 1'b1, "div_pre_rst");
        driveCycle(1, F_DIV, 32'd1000, 32'd3, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1'b1, 1'b1, "div_rst_cycle");
        modHi = '0;
        modLo = '0;
        rOp(F_MFLO, 0, 0, "post_rst_lo");
        rOp(F_MFHI, 0, 0, "post_rst_hi");

        $display("[TB] randomised mix");
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 3))
                    0:       f = F_MULT;
                    1:       f = F_MULTU;
                    2:       f = F_DIV;
                    default: f = F_DIVU;
                endcase
                applyStimulus(1, f, corner(), corner(), $urandom(), corner(), corner(), 2'b10, 0,
                              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "rand_muldiv");
                rOp(F_MFHI, 0, 0, "rand_mfhi");
                rOp(F_MFLO, 0, 0, "rand_mflo");
            end else begin
                f = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : fList[$urandom_range(0, 7)];
                applyStimulus(($urandom_range(0, 7) != 0), f, $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "rand_alu");
            end
        end

        repeat (2) @(negedge clk);
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
Parametrised successor to the single-cycle execute stage. Keeps the forwarding muxes, the ALU-source mux and the ALU, and adds an iterative multiply/divide unit with architectural HI/LO registers. MULT/MULTU/DIV/DIVU stall the pipeline for a fixed number of cycles. MFHI/MFLO read HI/LO as single-cycle ops. Sits between the ID/EX and EX/MEM pipeline registers; the hazard unit ORs `stall` into its PC/IF-ID/ID-EX hold.

Parameters:
- WIDTH, 32, datapath width; also the iteration count of the mul/div unit.
- MULDIV_EN, 1, 0 removes the mul/div unit and HI/LO: `stall` is tied to 0, MFHI/MFLO return 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_ex_valid  in  1  ID/EX holds a real instruction (not a bubble)
- id_ex_instr  in  32  instruction; funct = [5:0]
- reg1, reg2  in  WIDTH  register-file operands rs, rt
- id_ex_imm_value  in  WIDTH  sign-extended immediate
- ex_mem_alu_result  in  WIDTH  forward source, sel 2'b10
- mem_wb_write_back_result  in  WIDTH  forward source, sel 2'b01
- id_ex_alu_src  in  1  1 = immediate as operand B
- id_ex_alu_op  in  2  00 add, 01 sub, 10 funct-decoded, 11 reserved (result 0)
- Forward_A, Forward_B  in  2  00 reg, 01 MEM/WB, 10 EX/MEM, 11 zero
- alu_in2_out  out  WIDTH  forwarded rt, before the ALU-source mux (store data)
- alu_result  out  WIDTH  result
- stall  out  1  hold upstream stages and insert a bubble into EX/MEM

Behaviour:
- Reset: state IDLE, HI = LO = 0, counter 0, stall = 0. Reset mid-operation aborts, discards partial results and leaves HI/LO = 0.
- Operand A = Forward_A mux. Operand B = ALU-source mux over the Forward_B mux output. All single-cycle paths are combinational.
- Funct decode (alu_op = 10):
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 0/1).
  - 0x10 MFHI → HI, 0x12 MFLO → LO.
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU are muldiv ops.
  - Any other funct → 0.
  - Add/sub wrap modulo 2^WIDTH; no overflow trap.
- Issue: id_ex_valid && muldiv op && state IDLE.
- Issue cycle:
  - stall = 1 combinationally; alu_result = 0.
  - Forwarded A and B are latched, with magnitudes for signed ops.
  - Signs are recorded; next state is CALC with counter = WIDTH-1.
- CALC:
  - Multiply: one radix-2 shift-add step per cycle on a 2·WIDTH product register.
  - Divide: one restoring shift-subtract step per cycle.
  - stall = 1; counter decrements; leave for FIX when counter = 0 after the step (WIDTH cycles in CALC).
- FIX:
  - stall = 0, so upstream advances this cycle; alu_result = 0.
  - Sign fix-up, then HI/LO written at the clock edge ending FIX; next state IDLE.
  - An MFHI/MFLO entering EX on the following cycle sees the new value.
- Timing: stall is high for exactly WIDTH+1 cycles per muldiv op (33 at WIDTH = 32). Issue-to-HI/LO-valid is WIDTH+2 edges.
- Mult result: {HI,LO} = full 2·WIDTH product. For signed ops, negate the product if the operand signs differ.
- Div result: LO = quotient, HI = remainder. Signed: quotient negated if the signs differ; remainder takes the dividend's sign.
- Divide by zero: no trap. LO = all ones, HI = original rs; sign fix-up is bypassed.
- Signed MIN / -1: LO = MIN, HI = 0, which falls out of magnitude arithmetic.
- MFHI/MFLO in EX while state is not IDLE cannot occur, because upstream is stalled. The EX/MEM bubble carries alu_result = 0.
- id_ex_valid = 0 never issues.
- A muldiv presented in FIX is the same instruction already being retired and is not re-issued. It must have advanced: the hazard unit clears ID/EX on the FIX advance.

Decomposition:
- Shared package (mips_pkg): ALU-control encodings, funct constants (FUNCT_MULT…FUNCT_MFLO), ALU_OP_* codes, FWD_* select codes, muldiv FSM state enum {IDLE, CALC, FIX}.
- Sub-module `muldiv_iter`: start / signed / is_div / a / b inputs; busy, done, hi, lo outputs. Holds the FSM, counter, product/remainder registers and fix-up logic.
- The top level keeps forwarding, the ALU, the result mux and the HI/LO registers.

Test Plan:
1. Forwarding/ALU: reg1 = 5, ex_mem = 7, Forward_A = 10, reg2 = 3, funct 0x22, alu_op 10 → alu_result = 4, stall = 0. Forward_B = 01, mem_wb = 9 → alu_in2_out = 9.
2. MULTU 0xFFFFFFFF × 2 → stall high 33 cycles then low for 1 (FIX). Next-cycle MFHI → 1, MFLO → 0xFFFFFFFE.
3. DIV -7 / 2 → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 7.
4. MULT 0x80000000 × -1 → HI = 0, LO = 0x80000000. DIV 0x80000000 / -1 → LO = 0x80000000, HI = 0.
5. Assert reset at CALC cycle 10 of a DIV → stall = 0 the next cycle, state IDLE, MFLO returns 0. An id_ex_valid = 0 muldiv funct never raises stall.
6. MULDIV_EN = 0 build: MULT → stall stays 0, alu_result = 0; MFHI → 0.
